// File: rtl/qrs_peak_locator.sv
// R-peak locator: tracks the maximum sample inside each QRS window and, at window
// close, reports amplitude, timestamp, RR interval to the previous beat and beat count.
module qrs_peak_locator #(
  parameter int DATA_WIDTH     = 11,
  parameter int CTR_WIDTH      = 22,
  parameter int BEAT_CTR_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  logic                             i_ce,
  input  logic [CTR_WIDTH-1:0]             i_ctr,
  input  logic signed [DATA_WIDTH-1:0]     i_signal_in,
  input  logic                             i_qrs_win_active,
  output logic                             o_peak_valid,
  output logic signed [DATA_WIDTH-1:0]     o_peak_amp,
  output logic [CTR_WIDTH-1:0]             o_peak_time,
  output logic [CTR_WIDTH-1:0]             o_rr_interval,
  output logic                             o_rr_valid,
  output logic [BEAT_CTR_WIDTH-1:0]        o_beat_count
);

  typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

  state_t                          state;
  logic                            have_sample;
  logic                            prev_valid;
  logic signed [DATA_WIDTH-1:0]    max_amp;
  logic [CTR_WIDTH-1:0]            max_time;
  logic [CTR_WIDTH-1:0]            prev_time;

  // Unsigned modular difference, so a counter wrap between beats still yields the true gap.
  function automatic logic [CTR_WIDTH-1:0] rr_delta(input logic [CTR_WIDTH-1:0] now_t,
                                                    input logic [CTR_WIDTH-1:0] prev_t);
    rr_delta = now_t - prev_t;
  endfunction

  function automatic logic [BEAT_CTR_WIDTH-1:0] sat_inc(input logic [BEAT_CTR_WIDTH-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state         <= IDLE;
      have_sample   <= 1'b0;
      prev_valid    <= 1'b0;
      max_amp       <= '0;
      max_time      <= '0;
      prev_time     <= '0;
      o_peak_valid  <= 1'b0;
      o_peak_amp    <= '0;
      o_peak_time   <= '0;
      o_rr_interval <= '0;
      o_rr_valid    <= 1'b0;
      o_beat_count  <= '0;
    end else begin
      o_peak_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_qrs_win_active) begin
            state <= SEARCH;
            if (i_ce) begin
              max_amp     <= i_signal_in;
              max_time    <= i_ctr;
              have_sample <= 1'b1;
            end else begin
              have_sample <= 1'b0;
            end
          end
        end
        SEARCH: begin
          if (i_qrs_win_active) begin
            // Strict compare keeps the earliest sample on ties.
            if (i_ce && (!have_sample || (i_signal_in > max_amp))) begin
              max_amp     <= i_signal_in;
              max_time    <= i_ctr;
              have_sample <= 1'b1;
            end
          end else if (have_sample) begin
            state         <= REPORT;
            o_peak_valid  <= 1'b1;
            o_peak_amp    <= max_amp;
            o_peak_time   <= max_time;
            o_rr_interval <= rr_delta(max_time, prev_time);
            o_rr_valid    <= prev_valid;
            o_beat_count  <= sat_inc(o_beat_count);
            prev_time     <= max_time;
            prev_valid    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        REPORT: begin
          // Samples in this cycle are dropped; the detector's refractory gap makes that harmless.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qrs_peak_locator.sv
// Directed bench for qrs_peak_locator: per-cycle vector table plus a reset-mid-window sequence.
module tb_qrs_peak_locator;

  logic               i_clk = 1'b0;
  logic               i_nrst;
  logic               i_ce;
  logic [21:0]        i_ctr;
  logic signed [10:0] i_signal_in;
  logic               i_qrs_win_active;

  logic               o_peak_valid;
  logic signed [10:0] o_peak_amp;
  logic [21:0]        o_peak_time;
  logic [21:0]        o_rr_interval;
  logic               o_rr_valid;
  logic [15:0]        o_beat_count;

  logic               s_peak_valid;
  logic signed [10:0] s_peak_amp;
  logic [21:0]        s_peak_time;
  logic [21:0]        s_rr_interval;
  logic               s_rr_valid;
  logic [1:0]         s_beat_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  qrs_peak_locator dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_ce(i_ce), .i_ctr(i_ctr),
    .i_signal_in(i_signal_in), .i_qrs_win_active(i_qrs_win_active),
    .o_peak_valid(o_peak_valid), .o_peak_amp(o_peak_amp), .o_peak_time(o_peak_time),
    .o_rr_interval(o_rr_interval), .o_rr_valid(o_rr_valid), .o_beat_count(o_beat_count)
  );

  // Narrow beat counter instance so saturation is reachable in a short run.
  qrs_peak_locator #(.BEAT_CTR_WIDTH(2)) dut_sat (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_ce(i_ce), .i_ctr(i_ctr),
    .i_signal_in(i_signal_in), .i_qrs_win_active(i_qrs_win_active),
    .o_peak_valid(s_peak_valid), .o_peak_amp(s_peak_amp), .o_peak_time(s_peak_time),
    .o_rr_interval(s_rr_interval), .o_rr_valid(s_rr_valid), .o_beat_count(s_beat_count)
  );

  typedef struct {
    logic               win;
    logic               ce;
    logic [21:0]        ctr;
    logic signed [10:0] sig;
    logic               e_vld;
    logic signed [10:0] e_amp;
    logic [21:0]        e_time;
    logic [21:0]        e_rr;
    logic               e_rrv;
    logic [15:0]        e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Held expectations: outputs keep their last reported values between beats.
  logic signed [10:0] h_amp  = '0;
  logic [21:0]        h_time = '0;
  logic [21:0]        h_rr   = '0;
  logic               h_rrv  = 1'b0;
  logic [15:0]        h_cnt  = '0;

  task automatic row(input logic win, input logic ce, input logic [21:0] ctr,
                     input logic signed [10:0] sig);
    vec_t v;
    v.win = win; v.ce = ce; v.ctr = ctr; v.sig = sig; v.e_vld = 1'b0;
    v.e_amp = h_amp; v.e_time = h_time; v.e_rr = h_rr; v.e_rrv = h_rrv; v.e_cnt = h_cnt;
    vecs.push_back(v);
  endtask

  // Window closes this cycle; report lands at this edge.
  task automatic rep(input logic signed [10:0] amp, input logic [21:0] t,
                     input logic [21:0] rr, input logic rrv, input logic [15:0] cnt);
    vec_t v;
    h_amp = amp; h_time = t; h_rr = rr; h_rrv = rrv; h_cnt = cnt;
    v.win = 1'b0; v.ce = 1'b0; v.ctr = '0; v.sig = '0; v.e_vld = 1'b1;
    v.e_amp = amp; v.e_time = t; v.e_rr = rr; v.e_rrv = rrv; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic win, input logic ce, input logic [21:0] ctr,
                       input logic signed [10:0] sig);
    i_qrs_win_active = win; i_ce = ce; i_ctr = ctr; i_signal_in = sig;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic vld, input logic signed [10:0] amp,
                         input logic [21:0] t, input logic [21:0] rr, input logic rrv,
                         input logic [15:0] cnt);
    logic [15:0] sat;
    sat = (cnt > 16'd3) ? 16'd3 : cnt;
    chk({tag, " valid"}, 64'(o_peak_valid), 64'(vld));
    chk({tag, " amp"},   64'(o_peak_amp),   64'(amp));
    chk({tag, " time"},  64'(o_peak_time),  64'(t));
    chk({tag, " rr"},    64'(o_rr_interval), 64'(rr));
    chk({tag, " rrv"},   64'(o_rr_valid),   64'(rrv));
    chk({tag, " count"}, 64'(o_beat_count), 64'(cnt));
    chk({tag, " satcount"}, 64'(s_beat_count), 64'(sat));
  endtask

  initial begin
    i_nrst = 1'b0; i_ce = 1'b0; i_ctr = '0; i_signal_in = '0; i_qrs_win_active = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all("reset", 1'b0, 11'sd0, 22'd0, 22'd0, 1'b0, 16'd0);
    i_nrst = 1'b1;

    // Beat 1: tie at 40 keeps ctr 101; ce-low cycle with a large value is ignored.
    row(1, 1, 100, 10);  row(1, 1, 101, 40);  row(1, 0, 101, 99);
    row(1, 1, 102, -3);  row(1, 1, 103, 40);  row(1, 1, 104, 25);
    rep(40, 101, 101, 0, 1);
    row(0, 0, 0, 0);
    row(0, 1, 200, 500);
    // Beat 2
    row(1, 1, 398, 20);  row(1, 1, 399, 30);  row(1, 1, 400, 55);  row(1, 1, 401, 50);
    rep(55, 400, 299, 1, 2);
    row(0, 0, 0, 0);
    // Beat 3 near counter top, then beat 4 after wrap
    row(1, 1, 4194299, 5);  row(1, 1, 4194300, 60);
    rep(60, 4194300, 4193900, 1, 3);
    row(0, 0, 0, 0);
    row(1, 1, 19, 10);  row(1, 1, 20, 70);  row(1, 1, 21, -100);
    rep(70, 20, 24, 1, 4);
    row(0, 0, 0, 0);
    // All-negative window
    row(1, 1, 30, -50);  row(1, 1, 31, -7);  row(1, 1, 32, -20);
    rep(-7, 31, 11, 1, 5);
    row(0, 0, 0, 0);
    // Window with no sample strobes: no report
    row(1, 0, 40, 300);  row(1, 0, 41, 300);  row(1, 0, 42, 300);
    row(0, 0, 0, 0);  row(0, 0, 0, 0);  row(0, 0, 0, 0);
    // Single-sample window, then a window rising during the report cycle
    row(1, 1, 50, 8);
    rep(8, 50, 19, 1, 6);
    row(1, 1, 60, 99);
    row(1, 1, 61, 12);  row(1, 1, 62, 9);
    rep(12, 61, 11, 1, 7);
    row(0, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].win, vecs[k].ce, vecs[k].ctr, vecs[k].sig);
      chk_all($sformatf("row%0d", k), vecs[k].e_vld, vecs[k].e_amp, vecs[k].e_time,
              vecs[k].e_rr, vecs[k].e_rrv, vecs[k].e_cnt);
    end

    // Reset in the middle of a window discards it.
    drive(1, 1, 300, 90);
    drive(1, 1, 301, 95);
    chk("pre-reset valid", 64'(o_peak_valid), 64'(0));
    i_nrst = 1'b0;
    drive(1, 1, 302, 97);
    chk_all("midreset", 1'b0, 11'sd0, 22'd0, 22'd0, 1'b0, 16'd0);
    i_nrst = 1'b1;
    drive(1, 0, 303, 0);
    drive(1, 0, 304, 0);
    drive(0, 0, 0, 0);
    chk_all("post-reset tail", 1'b0, 11'sd0, 22'd0, 22'd0, 1'b0, 16'd0);
    drive(0, 0, 0, 0);
    drive(1, 1, 500, 33);
    drive(1, 1, 501, 44);
    chk("pre-close valid", 64'(o_peak_valid), 64'(0));
    drive(0, 0, 0, 0);
    chk_all("first-after-reset", 1'b1, 11'sd44, 22'd501, 22'd501, 1'b0, 16'd1);
    drive(0, 0, 0, 0);
    chk_all("pulse end", 1'b0, 11'sd44, 22'd501, 22'd501, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
